// File: rtl/brisc_pkg.sv
// Shared processor definitions: instruction memory geometry and loader FSM state types.
package brisc_pkg;
  localparam int INSTR_W     = 16;
  localparam int IMEM_DEPTH  = 32;
  localparam int IMEM_ADDR_W = 5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    WA_HI,
    WA_LO,
    WA_DONE
  } wa_state_t;
endpackage

// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port: strobe, address and word travel together.
interface uart_program_loader_if
  import brisc_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INSTR_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer, mid-bit sampling, glitch and framing checks.
module uart_rx_byte
  import brisc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);
  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_s_q;
  rx_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Shift register holds the last byte and needs no reset; valid_q qualifies it.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        timer_d = '0;
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = shift_q;
  assign frame_err_o  = ferr_q;
endmodule

// File: rtl/uart_program_loader.sv
// Pairs received bytes into 16-bit instructions and writes them sequentially into instruction memory.
module uart_program_loader
  import brisc_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = IMEM_DEPTH,
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int GAP_BITS = 20
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   UART_TXD_IN,
  uart_program_loader_if.master  imem,
  output logic                   load_done,
  output logic                   frame_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int GAP_CYC      = GAP_BITS * CLKS_PER_BIT;
  localparam int GW           = $clog2(GAP_CYC + 1);
  localparam int CW           = ADDR_W + 1;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .rx_i         (UART_TXD_IN),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (rx_ferr)
  );

  wa_state_t          state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic               done_q, done_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WA_HI;
      hi_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    unique case (state_q)
      WA_HI: begin
        gap_d = '0;
        if (byte_valid) begin
          hi_d    = byte_data;
          state_d = WA_LO;
        end
      end
      WA_LO: begin
        // A low byte arriving on the timeout cycle still completes the word.
        if (byte_valid) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          data_d  = {hi_q, byte_data};
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(DEPTH - 1)) ? WA_DONE : WA_HI;
        end else if (rx_ferr || gap_q == GW'(GAP_CYC - 1)) begin
          state_d = WA_HI;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      WA_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = WA_HI;
    endcase
  end

  assign imem.wr_en   = wr_en_q;
  assign imem.wr_addr = addr_q;
  assign imem.wr_data = data_q;
  assign load_done    = done_q;
  assign frame_err    = rx_ferr;
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for the UART program loader at 16 clocks per bit, 4-word image.
module tb_uart_program_loader;
  import brisc_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rxd = 1'b1;
  logic load_done, frame_err;

  uart_program_loader_if #(.ADDR_W(5), .DATA_W(16)) imem ();

  uart_program_loader #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000),
    .DEPTH    (4),
    .ADDR_W   (5),
    .GAP_BITS (20)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .UART_TXD_IN (rxd),
    .imem        (imem),
    .load_done   (load_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          ferr_n, bv_n, done_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      ferr_n   = 0;
      bv_n     = 0;
      done_cyc = -1;
    end else begin
      if (imem.wr_en) begin
        wa_q.push_back(imem.wr_addr);
        wd_q.push_back(imem.wr_data);
        wc_q.push_back(cyc);
      end
      if (frame_err) ferr_n++;
      if (dut.u_rx.byte_valid_o) bv_n++;
      if (load_done && done_cyc < 0) done_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int last_start = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] wd_at(input int i);
    return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wa_at(input int i);
    return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    @(posedge clk); #1;
    rxd = 1'b0;
    last_start = cyc;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    rxd = stopv;
    repeat (CPB) @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(imem.wr_en), 32'h0);
    chk("rst_wr_addr", 32'(imem.wr_addr), 32'h0);
    chk("rst_wr_data", 32'(imem.wr_data), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, including write latency from the low frame's start edge.
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (10) @(negedge clk);
    chk("w1_count", 32'(wd_q.size()), 32'd1);
    chk("w1_data", wd_at(0), 32'h1234);
    chk("w1_addr", wa_at(0), 32'h0);
    chk("w1_latency", (wc_q.size() > 0) ? 32'(wc_q[0] - last_start) : 32'hDEAD_BEEF, 32'd156);
    chk("w1_no_done", 32'(load_done), 32'h0);

    // Full image, then further bytes must not write.
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'hA0 + 8'(i), 1'b1);
    repeat (10) @(negedge clk);
    chk("full_count", 32'(wd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_data%0d", i), wd_at(i),
          32'({8'hA0 + 8'(2 * i), 8'hA1 + 8'(2 * i)}));
      chk($sformatf("full_addr%0d", i), wa_at(i), 32'(i));
    end
    chk("done_set", 32'(load_done), 32'h1);
    chk("done_timing", (wc_q.size() == 4) ? 32'(done_cyc - wc_q[3]) : 32'hDEAD_BEEF, 32'd1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (10) @(negedge clk);
    chk("post_done_nowrite", 32'(wd_q.size()), 32'd4);
    chk("done_sticky", 32'(load_done), 32'h1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("done_async_clear", 32'(load_done), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Framing error drops the byte; the following pair lands at address 0.
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_pulse", 32'(ferr_n), 32'd1);
    chk("ferr_nowrite", 32'(wd_q.size()), 32'd0);
    send_frame(8'hBE, 1'b1);
    send_frame(8'hEF, 1'b1);
    repeat (10) @(negedge clk);
    chk("ferr_next_count", 32'(wd_q.size()), 32'd1);
    chk("ferr_next_data", wd_at(0), 32'hBEEF);
    chk("ferr_next_addr", wa_at(0), 32'h0);

    // Orphaned high byte is discarded after the idle gap.
    do_reset();
    send_frame(8'h11, 1'b1);
    repeat (21 * CPB) @(negedge clk);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    repeat (10) @(negedge clk);
    chk("gap_count", 32'(wd_q.size()), 32'd1);
    chk("gap_data", wd_at(0), 32'h2233);
    chk("gap_addr", wa_at(0), 32'h0);

    // Short low pulse is rejected as a glitch.
    do_reset();
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (4) @(posedge clk); #1;
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_byte", 32'(bv_n), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_n), 32'd0);
    chk("glitch_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));

    // Reset with a word written and a high byte pending restarts at address 0.
    do_reset();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    repeat (5) @(negedge clk);
    chk("rst_mid_prewrite", 32'(wd_q.size()), 32'd1);
    do_reset();
    chk("rst_mid_done", 32'(load_done), 32'h0);
    send_frame(8'hCA, 1'b1);
    send_frame(8'hFE, 1'b1);
    repeat (10) @(negedge clk);
    chk("rst_mid_count", 32'(wd_q.size()), 32'd1);
    chk("rst_mid_data", wd_at(0), 32'hCAFE);
    chk("rst_mid_addr", wa_at(0), 32'h0);
    chk("rst_mid_done2", 32'(load_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
